// File: rtl/ntt_coeff_io.sv
// Purpose: loads a polynomial into the two coefficient BRAMs, kicks the NTT core, streams the result back out.
// Latency: 5 cycles per 4 input beats on load, 2 cycles from UNL_RD to first m_valid, 6 cycles per output group.
// Backpressure: s_ready low outside IDLE/LOAD; m_data/m_valid hold while m_ready is low. Build option NTT_IO_LOOPBACK_EN bypasses the core.
module ntt_coeff_io #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int N_COEFF = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              core_start,
  input  logic              core_done,
  output logic              io_sel,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr0_a,
  output logic [ADDR_W-1:0] mem_addr0_b,
  output logic [ADDR_W-1:0] mem_addr1_a,
  output logic [ADDR_W-1:0] mem_addr1_b,
  output logic [DATA_W-1:0] mem_din0,
  output logic [DATA_W-1:0] mem_din1,
  output logic [DATA_W-1:0] mem_din2,
  output logic [DATA_W-1:0] mem_din3,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout0_a,
  input  logic [DATA_W-1:0] mem_dout0_b,
  input  logic [DATA_W-1:0] mem_dout1_a,
  input  logic [DATA_W-1:0] mem_dout1_b
);

  localparam int NG = N_COEFF / 4;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(NG - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_LD_WR, S_START, S_WAIT, S_UNL_RD, S_UNL_CAP, S_UNL_OUT, S_FIN
  } state_t;

  state_t                   state, nxt_state;
  logic [GW-1:0]            g, nxt_g;
  logic [1:0]               k, nxt_k;
  logic [3:0][DATA_W-1:0]   lane, nxt_lane;
  logic [DATA_W-1:0]        nxt_m_data;
  logic                     nxt_m_last;
  logic [ADDR_W-1:0]        nxt_addr_even;
  logic                     s_hs, m_hs;

  assign s_hs = s_valid & s_ready;
  assign m_hs = m_valid & m_ready;

  // Sequencing: lane capture, group/lane counters and next output beat.
  always_comb begin
    nxt_state  = state;
    nxt_g      = g;
    nxt_k      = k;
    nxt_lane   = lane;
    nxt_m_data = m_data;
    nxt_m_last = m_last;
    case (state)
      S_IDLE: begin
        if (s_hs) begin
          nxt_lane[0] = s_data;
          nxt_k       = 2'd1;
          nxt_state   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (s_hs) begin
          nxt_lane[k] = s_data;
          nxt_k       = k + 2'd1;
          if (k == 2'd3) nxt_state = S_LD_WR;
        end
      end
      S_LD_WR: begin
        nxt_k = 2'd0;
        if (g == G_LAST) begin
          nxt_g = '0;
`ifdef NTT_IO_LOOPBACK_EN
          nxt_state = S_UNL_RD;
`else
          nxt_state = S_START;
`endif
        end else begin
          nxt_g     = g + GW'(1);
          nxt_state = S_LOAD;
        end
      end
      S_START: nxt_state = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          nxt_g     = '0;
          nxt_state = S_UNL_RD;
        end
      end
      S_UNL_RD: nxt_state = S_UNL_CAP;
      S_UNL_CAP: begin
        // Read data returns one cycle after the UNL_RD address; first beat is lane 0.
        nxt_lane   = {mem_dout1_b, mem_dout1_a, mem_dout0_b, mem_dout0_a};
        nxt_k      = 2'd0;
        nxt_m_data = mem_dout0_a;
        nxt_m_last = 1'b0;
        nxt_state  = S_UNL_OUT;
      end
      S_UNL_OUT: begin
        if (m_hs) begin
          nxt_k = k + 2'd1;
          if (k == 2'd3) begin
            nxt_m_last = 1'b0;
            if (g == G_LAST) begin
              nxt_g     = '0;
              nxt_state = S_FIN;
            end else begin
              nxt_g     = g + GW'(1);
              nxt_state = S_UNL_RD;
            end
          end else begin
            nxt_m_data = lane[k + 2'd1];
            nxt_m_last = (g == G_LAST) && (k == 2'd2);
          end
        end
      end
      S_FIN:   nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
    nxt_addr_even = ADDR_W'(nxt_g) << 1;
  end

  // State, counters and lane registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      g     <= '0;
      k     <= '0;
      lane  <= '0;
    end else begin
      state <= nxt_state;
      g     <= nxt_g;
      k     <= nxt_k;
      lane  <= nxt_lane;
    end
  end

  // Registered outputs decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready     <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      core_start  <= 1'b0;
      io_sel      <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr0_a <= '0;
      mem_addr0_b <= '0;
      mem_addr1_a <= '0;
      mem_addr1_b <= '0;
      mem_din0    <= '0;
      mem_din1    <= '0;
      mem_din2    <= '0;
      mem_din3    <= '0;
    end else begin
      s_ready    <= (nxt_state == S_IDLE) || (nxt_state == S_LOAD);
      m_valid    <= (nxt_state == S_UNL_OUT);
      m_data     <= nxt_m_data;
      m_last     <= nxt_m_last;
      core_start <= (nxt_state == S_START);
      io_sel     <= !((nxt_state == S_START) || (nxt_state == S_WAIT));
      busy       <= (nxt_state != S_IDLE);
      done       <= (nxt_state == S_FIN);
      mem_we     <= (nxt_state == S_LD_WR);
      // Addresses only move when a group is written or read; they hold while the core owns the BRAMs.
      if ((nxt_state == S_LD_WR) || (nxt_state == S_UNL_RD)) begin
        mem_addr0_a <= nxt_addr_even;
        mem_addr0_b <= nxt_addr_even | ADDR_W'(1);
        mem_addr1_a <= nxt_addr_even;
        mem_addr1_b <= nxt_addr_even | ADDR_W'(1);
      end
      if (nxt_state == S_LD_WR) begin
        mem_din0 <= nxt_lane[0];
        mem_din1 <= nxt_lane[1];
        mem_din2 <= nxt_lane[2];
        mem_din3 <= nxt_lane[3];
      end
    end
  end

endmodule

// File: doc/ntt_coeff_io.md
# ntt_coeff_io

Host-side coefficient mover for the radix-4 NTT/INTT datapath. It loads a polynomial from a valid/ready input stream into the two dual-port coefficient BRAMs, four coefficients per write. It then pulses the core start, waits for core completion, and reads the transformed polynomial back out as a valid/ready output stream. It sits beside `ntt_intt` on the BRAM ports, with a top-level mux selected by `io_sel`.

## Interface
- `DATA_W`, 32: coefficient width.
- `ADDR_W`, 8: BRAM address width.
- `N_COEFF`, 256: coefficients per polynomial; a multiple of 4, with N_COEFF/2 ≤ 2^ADDR_W.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `s_data` in DATA_W: input coefficient, natural order.
- `s_valid` in 1 / `s_ready` out 1: input handshake.
- `m_data` out DATA_W: output coefficient, natural order.
- `m_valid` out 1 / `m_ready` in 1: output handshake.
- `m_last` out 1: high with coefficient N_COEFF-1.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_done` in 1: core completion, sampled only in WAIT.
- `io_sel` out 1: 1 means this block owns the BRAM ports.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse after the last output beat.
- `mem_addr0_a`, `mem_addr0_b`, `mem_addr1_a`, `mem_addr1_b` out ADDR_W: BRAM0 and BRAM1 port addresses.
- `mem_din0`..`mem_din3` out DATA_W: write data for BRAM0.a, BRAM0.b, BRAM1.a and BRAM1.b respectively.
- `mem_we` out 1: shared write enable.
- `mem_dout0_a`, `mem_dout0_b`, `mem_dout1_a`, `mem_dout1_b` in DATA_W: BRAM read data, 1-cycle latency.

## Operation
- **Storage map:** group g = i/4 and lane k = i%4.
  - k0 → BRAM0[2g], k1 → BRAM0[2g+1].
  - k2 → BRAM1[2g], k3 → BRAM1[2g+1].
  - Addresses are always driven as a.2g and b.2g+1 on both BRAMs.
- **States:** IDLE, LOAD, LD_WR, START, WAIT, UNL_RD, UNL_CAP, UNL_OUT, FIN.
- **IDLE:** `s_ready`=1. The first `s_valid` handshake captures into lane 0 and moves to LOAD.
- **LOAD:** `s_ready`=1; each handshake captures into lane[k] and increments k. The handshake on k=3 moves to LD_WR.
- **LD_WR:** `s_ready`=0 and `mem_we`=1 for exactly one cycle, with the lanes on `mem_din0..3` at group g.
  - Then g increments and k clears.
  - If g = N_COEFF/4-1 was just written, go to START; otherwise go to LOAD.
- **START:** `core_start`=1 for one cycle, `io_sel`=0, then go to WAIT.
- **WAIT:** `io_sel`=0. `core_done`=1 moves to UNL_RD with g cleared. `core_done` is ignored in every other state.
- **UNL_RD:** drive the group-g addresses, then go to UNL_CAP.
- **UNL_CAP:** register the four `mem_dout` values into lanes, then go to UNL_OUT.
- **UNL_OUT:** `m_valid`=1 and `m_data`=lane[k]. Each handshake increments k.
  - After the k=3 handshake, g increments.
  - If the last group just completed, go to FIN; otherwise go to UNL_RD.
- **FIN:** `done`=1 for one cycle, then go to IDLE.
- **`io_sel`:** 1 in every state except START and WAIT.
- **`m_data`** holds stable while `m_valid`=1 and `m_ready`=0.
- **Mid-operation reset:** asserting `rst` returns to IDLE and discards the partial polynomial. BRAM contents are not cleared.

## Timing
- **Reset values:** state=IDLE; g=0 and k=0.
- **Outputs low at reset:** `s_ready`, `m_valid`, `m_last`, `core_start`, `mem_we`, `busy` and `done` are 0.
- **Outputs high at reset:** `io_sel`=1.
- **Addresses and data at reset:** all addresses and `mem_din*` are 0.
- `s_ready` rises in the first cycle after reset release.
- All outputs are registered.
- **Load throughput:** 4 beats per 5 cycles at best. A 256-coefficient load takes ≥320 cycles.
- **Unload group latency:** from entering UNL_RD to the first `m_valid` is 2 cycles. At best, a group is 6 cycles.
- **Core latency:** `core_start` is asserted 1 cycle after the final LD_WR. The first unload address is driven 1 cycle after `core_done` is sampled.
- **Boundaries:**
  - `s_valid` outside IDLE/LOAD is not accepted (`s_ready`=0).
  - `m_ready` outside UNL_OUT is ignored.
  - g wraps to 0 on exit to FIN and START.

## Configuration
- `NTT_IO_LOOPBACK_EN` defined: LD_WR after the last group goes directly to UNL_RD. START and WAIT are unreachable, `core_start` stays 0, and the output equals the input. This is the memory-path bring-up mode.
- Undefined: normal sequence through START and WAIT.

## Test plan
- **Reset:** assert `rst`=0 mid-LOAD (after 37 beats). Required: all outputs return to their reset values immediately. A fresh load of 256 beats then completes normally.
- **Load map:** input i = 0x1000+i. Required:
  - exactly 64 `mem_we` pulses;
  - the pulse for group 5 carries addr0_a=10, addr0_b=11, din0=0x1014, din3=0x1017.
- **Loopback:** with `NTT_IO_LOOPBACK_EN`, load 0..255. Required: the output is 0..255 in order, `m_last` is high only on 255, `done` pulses once, and `core_start` never asserts.
- **Core handshake:** hold `core_done`=0 for 500 cycles after `core_start`. Required: `io_sel`=0 and no BRAM activity throughout. Raising `core_done` makes UNL_RD start 1 cycle later.
- **Backpressure:** randomize `m_ready` at 30%. Required: `m_data` is stable while stalled and no beats are lost or duplicated. Randomize `s_valid` gaps. Required: the write count stays at 64.
- **Spurious `core_done`:** pulse `core_done` during LOAD. Required: it is ignored and the state machine proceeds to START normally.
